// File: rtl/cpu64_l3_pkg.sv
// cpu64_l3_pkg: shared widths, FSM states and write-buffer entry layout
package cpu64_l3_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int BE_W = 8;
  localparam int L3_LINE_BYTES = 64;
  localparam int L3_WORD_BYTES = 8;
  localparam int WORD_OFF_W = $clog2(L3_WORD_BYTES);
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0] be;
    logic [DATA_W-1:0] wdata;
  } wbuf_entry_t;
endpackage

// File: rtl/cpu64_l3_wbuf_fifo.sv
// cpu64_l3_wbuf_fifo: posted-write FIFO storage with wrap-bit pointers
module cpu64_l3_wbuf_fifo
  import cpu64_l3_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  wbuf_entry_t              entry_i,
  input  logic                     pop_i,
  output wbuf_entry_t              head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  wbuf_entry_t mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q, wptr_d, rptr_d;
  assign wptr_d = wptr_q + (AW+1)'(push_i);
  assign rptr_d = rptr_q + (AW+1)'(pop_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= entry_i;
  end
  assign count_o = wptr_q - rptr_q;
  assign head_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = wptr_q == rptr_q;
  assign full_o = count_o == (AW+1)'(DEPTH);
endmodule

// File: rtl/cpu64_l3_mem_wbuf.sv
// cpu64_l3_mem_wbuf: posted write buffer between L3 and memory, reads stall until writes drain
module cpu64_l3_mem_wbuf
  import cpu64_l3_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [BE_W-1:0]     be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                req_o,
  output logic                we_o,
  output logic [BE_W-1:0]     be_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic                gnt_i,
  input  logic                rvalid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic                empty_o,
  output logic                full_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q;
  logic [ADDR_W-1:WORD_OFF_W] raddr_q;
  logic rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  wbuf_entry_t head;
  logic fifo_empty, fifo_full, wr_gnt, rd_gnt, is_wr, is_rd;
  logic [CW-1:0] fifo_cnt;
  assign wr_gnt = req_i && we_i && !fifo_full;
  assign rd_gnt = req_i && !we_i && fifo_empty && state_q == S_IDLE;
  assign gnt_o = wr_gnt || rd_gnt;
  assign is_wr = state_q == S_WR;
  assign is_rd = state_q == S_RD;
  cpu64_l3_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_gnt),
    .entry_i ('{addr: addr_i, be: be_i, wdata: wdata_i}),
    .pop_i   (is_wr && gnt_i),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );
  // a write accepted while idle starts the drain on the same edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (rd_gnt) begin
            raddr_q <= addr_i[ADDR_W-1:WORD_OFF_W];
            state_q <= S_RD;
          end else if (!fifo_empty || wr_gnt) state_q <= S_WR;
        end
        S_WR: if (gnt_i && fifo_cnt == CW'(1) && !wr_gnt) state_q <= S_IDLE;
        S_RD: if (gnt_i) state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (rvalid_i) begin
            rvalid_q <= 1'b1;
            rdata_q <= rdata_i;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign req_o = is_wr || is_rd;
  assign we_o = is_wr;
  assign be_o = is_wr ? head.be : is_rd ? '1 : '0;
  assign addr_o = is_wr ? head.addr : is_rd ? {raddr_q, {WORD_OFF_W{1'b0}}} : '0;
  assign wdata_o = is_wr ? head.wdata : '0;
  assign rvalid_o = rvalid_q;
  assign rdata_o = rdata_q;
  assign empty_o = fifo_empty && state_q == S_IDLE;
  assign full_o = fifo_full;
endmodule

// File: tb/tb_cpu64_l3_mem_wbuf.sv
// tb_cpu64_l3_mem_wbuf: directed scenarios checked against a queue-based transaction model
module tb_cpu64_l3_mem_wbuf;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_i, we_i, gnt_i, rvalid_i;
  logic [7:0] be_i;
  logic [63:0] addr_i, wdata_i, rdata_i;
  logic gnt_o, rvalid_o, req_o, we_o, empty_o, full_o;
  logic [7:0] be_o;
  logic [63:0] rdata_o, addr_o, wdata_o;
  always #5 clk = ~clk;
  cpu64_l3_mem_wbuf #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .empty_o(empty_o), .full_o(full_o)
  );
  int cc = 0, ce = 0, cm = 0, em = 0, wr_cnt = 0, base;
  task automatic chk_c(input string n, input logic [63:0] a, input logic [63:0] e);
    cc++;
    if (a !== e) begin
      ce++;
      $display("FAIL model_%s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic chk_m(input string n, input logic [63:0] a, input logic [63:0] e);
    cm++;
    if (a !== e) begin
      em++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  typedef struct {logic [63:0] a; logic [7:0] b; logic [63:0] d;} ent_t;
  ent_t q[$];
  bit draining = 0, m_rv = 0, wg, rg, was_idle;
  int rd_phase = 0;
  logic [63:0] raddr = '0, m_rdata = '0;
  function automatic bit m_wgnt();
    return req_i && we_i && q.size() < DEPTH;
  endfunction
  function automatic bit m_rgnt();
    return req_i && !we_i && q.size() == 0 && !draining && rd_phase == 0;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      draining = 0;
      rd_phase = 0;
      m_rv = 0;
      m_rdata = '0;
    end else begin
      wg = m_wgnt();
      rg = m_rgnt();
      was_idle = !draining && rd_phase == 0;
      if (draining && gnt_i) void'(q.pop_front());
      if (wg) q.push_back('{addr_i, be_i, wdata_i});
      m_rv = 0;
      m_rdata = '0;
      if (rd_phase == 2 && rvalid_i) begin
        m_rv = 1;
        m_rdata = rdata_i;
        rd_phase = 0;
      end else if (rd_phase == 1 && gnt_i) rd_phase = 2;
      if (rg) begin
        rd_phase = 1;
        raddr = {addr_i[63:3], 3'b000};
      end
      if (draining || (was_idle && !rg)) draining = q.size() != 0;
    end
  end
  always @(posedge clk) if (rst_n && req_o && we_o && gnt_i) wr_cnt++;
  always @(negedge clk) begin
    chk_c("gnt_o", 64'(gnt_o), 64'(m_wgnt() || m_rgnt()));
    chk_c("req_o", 64'(req_o), 64'(draining || rd_phase == 1));
    chk_c("we_o", 64'(we_o), 64'(draining));
    if (draining) begin
      chk_c("be_o", 64'(be_o), 64'(q[0].b));
      chk_c("addr_o", addr_o, q[0].a);
      chk_c("wdata_o", wdata_o, q[0].d);
    end else begin
      chk_c("be_o", 64'(be_o), rd_phase == 1 ? 64'hFF : 64'h0);
      chk_c("addr_o", addr_o, rd_phase == 1 ? raddr : 64'h0);
      chk_c("wdata_o", wdata_o, 64'h0);
    end
    chk_c("rvalid_o", 64'(rvalid_o), 64'(m_rv));
    chk_c("rdata_o", rdata_o, m_rdata);
    chk_c("empty_o", 64'(empty_o), 64'(q.size() == 0 && !draining && rd_phase == 0));
    chk_c("full_o", 64'(full_o), 64'(q.size() == DEPTH));
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    req_i = 0; we_i = 0; be_i = '0; addr_i = '0; wdata_i = '0;
  endtask
  task automatic set_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b);
    req_i = 1; we_i = 1; be_i = b; addr_i = a; wdata_i = d;
  endtask
  task automatic set_rd(input logic [63:0] a);
    req_i = 1; we_i = 0; be_i = '0; addr_i = a; wdata_i = '0;
  endtask
  initial begin
    idle_in();
    gnt_i = 0; rvalid_i = 0; rdata_i = '0;
    repeat (2) nxt();
    @(negedge clk);
    chk_m("rst_empty", 64'(empty_o), 64'h1);
    chk_m("rst_full", 64'(full_o), 64'h0);
    chk_m("rst_req", 64'(req_o), 64'h0);
    nxt();
    rst_n = 1;
    // single write
    gnt_i = 1;
    set_wr(64'h1000, 64'hA5A5, 8'hFF);
    @(negedge clk); chk_m("s1_gnt", 64'(gnt_o), 64'h1); nxt();
    idle_in();
    @(negedge clk);
    chk_m("s1_req", 64'(req_o), 64'h1);
    chk_m("s1_we", 64'(we_o), 64'h1);
    chk_m("s1_addr", addr_o, 64'h1000);
    chk_m("s1_wdata", wdata_o, 64'hA5A5);
    nxt();
    @(negedge clk); chk_m("s1_empty", 64'(empty_o), 64'h1); chk_m("s1_idle", 64'(req_o), 64'h0);
    nxt();
    // fill
    gnt_i = 0;
    for (int i = 0; i < 8; i++) begin
      set_wr(64'h4000 + 64'(8 * i), 64'(i), 8'h01 << i);
      @(negedge clk); chk_m("fill_gnt", 64'(gnt_o), 64'h1); nxt();
    end
    set_wr(64'h4040, 64'h8, 8'hF0);
    @(negedge clk); chk_m("fill_full", 64'(full_o), 64'h1); chk_m("ninth_stall", 64'(gnt_o), 64'h0); nxt();
    gnt_i = 1;
    @(negedge clk); chk_m("ninth_stall_deq", 64'(gnt_o), 64'h0); chk_m("drain0", addr_o, 64'h4000); nxt();
    @(negedge clk); chk_m("ninth_gnt", 64'(gnt_o), 64'h1); chk_m("drain1", addr_o, 64'h4008); nxt();
    idle_in();
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk); chk_m("drain_order", addr_o, 64'h4000 + 64'(8 * k)); nxt();
    end
    @(negedge clk); chk_m("fill_empty", 64'(empty_o), 64'h1); nxt();
    // read after write
    gnt_i = 0;
    set_wr(64'h2000, 64'h1111, 8'hFF);
    @(negedge clk); chk_m("raw_wgnt", 64'(gnt_o), 64'h1); nxt();
    set_rd(64'h2000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_m("raw_rd_stall", 64'(gnt_o), 64'h0); chk_m("raw_wr_first", addr_o, 64'h2000); nxt();
    end
    gnt_i = 1;
    @(negedge clk); chk_m("raw_rd_stall_deq", 64'(gnt_o), 64'h0); chk_m("raw_we", 64'(we_o), 64'h1); nxt();
    gnt_i = 0;
    @(negedge clk); chk_m("raw_rgnt", 64'(gnt_o), 64'h1); chk_m("raw_req_idle", 64'(req_o), 64'h0); nxt();
    idle_in();
    gnt_i = 1;
    @(negedge clk); chk_m("raw_rd_req", 64'(req_o), 64'h1); chk_m("raw_rd_we", 64'(we_o), 64'h0); nxt();
    gnt_i = 0; rvalid_i = 1; rdata_i = 64'h77;
    @(negedge clk); nxt();
    rvalid_i = 0; rdata_i = '0;
    @(negedge clk); chk_m("raw_rdata", rdata_o, 64'h77); nxt();
    // plain read
    set_rd(64'h3008);
    @(negedge clk); chk_m("rd_gnt", 64'(gnt_o), 64'h1); nxt();
    idle_in();
    gnt_i = 1;
    @(negedge clk); chk_m("rd_addr", addr_o, 64'h3008); chk_m("rd_be", 64'(be_o), 64'hFF); nxt();
    gnt_i = 0;
    @(negedge clk); chk_m("rd_wait_req", 64'(req_o), 64'h0); nxt();
    rvalid_i = 1; rdata_i = 64'hDEADBEEF;
    @(negedge clk); chk_m("rd_no_early", 64'(rvalid_o), 64'h0); nxt();
    rvalid_i = 0; rdata_i = '0;
    @(negedge clk); chk_m("rd_rvalid", 64'(rvalid_o), 64'h1); chk_m("rd_rdata", rdata_o, 64'hDEADBEEF); nxt();
    @(negedge clk); chk_m("rd_pulse", 64'(rvalid_o), 64'h0); chk_m("rd_rdata0", rdata_o, 64'h0); nxt();
    // write during read, misaligned read address
    set_rd(64'h500D);
    @(negedge clk); nxt();
    idle_in();
    gnt_i = 1;
    @(negedge clk); chk_m("wdr_align", addr_o, 64'h5008); nxt();
    set_wr(64'h6000, 64'h66, 8'h3C);
    @(negedge clk); chk_m("wdr_wgnt", 64'(gnt_o), 64'h1); chk_m("wdr_noreq", 64'(req_o), 64'h0); nxt();
    idle_in();
    rvalid_i = 1; rdata_i = 64'h55;
    @(negedge clk); chk_m("wdr_held", 64'(req_o), 64'h0); chk_m("wdr_nempty", 64'(empty_o), 64'h0); nxt();
    rvalid_i = 0; rdata_i = '0;
    @(negedge clk); chk_m("wdr_rvalid", 64'(rvalid_o), 64'h1); chk_m("wdr_still_held", 64'(req_o), 64'h0); nxt();
    @(negedge clk); chk_m("wdr_drain", addr_o, 64'h6000); chk_m("wdr_be", 64'(be_o), 64'h3C); nxt();
    @(negedge clk); chk_m("wdr_empty", 64'(empty_o), 64'h1); nxt();
    // reset mid-drain
    gnt_i = 0;
    for (int i = 0; i < 4; i++) begin
      set_wr(64'h7000 + 64'(8 * i), 64'(i + 16), 8'hFF);
      @(negedge clk); nxt();
    end
    idle_in();
    @(negedge clk); chk_m("rst_pre_req", 64'(req_o), 64'h1); nxt();
    rst_n = 0;
    #1;
    chk_m("rst_async_req", 64'(req_o), 64'h0);
    chk_m("rst_async_addr", addr_o, 64'h0);
    chk_m("rst_async_empty", 64'(empty_o), 64'h1);
    nxt();
    rst_n = 1;
    gnt_i = 1;
    base = wr_cnt;
    repeat (6) begin @(negedge clk); nxt(); end
    chk_m("rst_no_writes", 64'(wr_cnt - base), 64'h0);
    // reset mid-read
    gnt_i = 0;
    set_rd(64'h8000);
    @(negedge clk); nxt();
    idle_in();
    gnt_i = 1;
    @(negedge clk); nxt();
    gnt_i = 0;
    rst_n = 0;
    nxt();
    rst_n = 1;
    rvalid_i = 1; rdata_i = 64'h1234;
    @(negedge clk); nxt();
    rvalid_i = 0; rdata_i = '0;
    @(negedge clk); chk_m("rst_rd_norvalid", 64'(rvalid_o), 64'h0); nxt();
    $display("CHECKS %0d ERRORS %0d", cc + cm, ce + em);
    $finish;
  end
endmodule

// File: doc/cpu64_l3_mem_wbuf.md
CPU64_L3_MEM_WBUF -- requirements
Module: cpu64_l3_mem_wbuf

Interface
REQ-001 SHALL have parameter: DEPTH, 8, posted-write entries; power of two, minimum 2.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, in order:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
req_i  in  1  request from L3 memory port
we_i  in  1  1=write, 0=read
be_i  in  8  byte enables
addr_i  in  64  byte address
wdata_i  in  64  write data
gnt_o  out  1  request accepted
rvalid_o  out  1  read data valid
rdata_o  out  64  read data
req_o  out  1  request to external memory
we_o  out  1  write
be_o  out  8  byte enables
addr_o  out  64  address
wdata_o  out  64  write data
gnt_i  in  1  memory accepted request
rvalid_i  in  1  memory read data valid
rdata_i  in  64  memory read data
empty_o  out  1  buffer empty and port idle
full_o  out  1  buffer holds DEPTH entries

Function
REQ-004 SHALL hold a FIFO of {addr, be, wdata} entries, with pointers of log2(DEPTH)+1 bits.
REQ-005 The write grant SHALL be combinational: gnt_o=1 when req_i && we_i && !full_o, with the entry enqueued on that edge.
REQ-006 Fullness SHALL be evaluated at cycle start: a write arriving while full SHALL NOT be granted, even if a dequeue occurs in the same cycle.
REQ-007 The read grant SHALL be gnt_o=1 when req_i && !we_i && FIFO empty && state==S_IDLE; otherwise gnt_o=0 and the read stalls until drained (read-after-write ordering).
REQ-008 The FSM SHALL have states S_IDLE, S_WR, S_RD, S_RD_WAIT.
REQ-009 In S_IDLE:
- Granted read: latch addr_i, go to S_RD.
- Else FIFO non-empty: go to S_WR.
- A granted read takes priority only when the FIFO is empty, so the priority never conflicts.
REQ-010 In S_WR, the head entry SHALL drive req_o=1, we_o=1, be_o=entry be, addr_o, wdata_o.
- On gnt_i: dequeue.
- Stay in S_WR if another entry remains after dequeue, else go to S_IDLE.
REQ-011 In S_RD: req_o=1, we_o=0, be_o=8'hFF, addr_o={latched addr[63:3],3'b0}, wdata_o=0. On gnt_i, go to S_RD_WAIT.
REQ-012 In S_RD_WAIT, on rvalid_i: rvalid_o=1 and rdata_o=rdata_i on the next cycle (registered), then go to S_IDLE.
REQ-013 rvalid_o SHALL be a single-cycle pulse; rdata_o SHALL be 0 when rvalid_o=0.
REQ-014 Writes SHALL be granted in any state, including during S_RD/S_RD_WAIT, subject to REQ-005.
REQ-015 Downstream outputs SHALL depend only on registered state and FIFO contents; no combinational path from upstream inputs to req_o/addr_o/wdata_o.
REQ-016 When req_o=0, all downstream outputs SHALL be 0.
REQ-017 Latencies:
- Write enqueued on edge N SHALL present req_o no earlier than cycle N+1.
- Read granted on edge N SHALL present req_o in cycle N+1.
REQ-018 The FIFO SHALL keep write order, with no merging or forwarding.
REQ-019 Status flags:
- empty_o = FIFO empty && state==S_IDLE.
- full_o = count==DEPTH.
REQ-020 Simultaneous enqueue and dequeue SHALL leave the count unchanged. Pointers SHALL wrap modulo 2*DEPTH.

Reset
REQ-021 On rst_ni low, asynchronously:
- state=S_IDLE, pointers=0.
- All registered outputs 0; empty_o=1, full_o=0.
- Buffered entries discarded.
REQ-022 Reset mid-drain or mid-read SHALL abandon the transaction; no rvalid_o after reset release.

Structure
REQ-023 Package cpu64_l3_pkg SHALL hold the state encoding, L3 line and word widths, and the address/data/be width constants.
REQ-024 The FIFO storage and pointers SHALL be sub-module cpu64_l3_wbuf_fifo; the top SHALL contain the FSM and port muxing.

Verification
REQ-025 Bench SHALL cover these scenarios:
- Single write: addr=0x1000, wdata=0xA5A5, be=0xFF, gnt_i held 1 -> gnt_o same cycle; req_o/we_o=1, addr_o=0x1000 next cycle; empty_o=1 after gnt_i.
- Fill: 8 back-to-back writes with gnt_i=0 -> full_o=1 after 8th; 9th gets gnt_o=0. Release gnt_i -> addr_o sequence in enqueue order; 9th granted the cycle after first dequeue.
- RAW ordering: write 0x2000 then read 0x2000 with gnt_i delayed 3 cycles -> read gnt_o only after the write dequeues; write reaches memory before read req_o.
- Read: read 0x3008, memory rvalid_i with rdata_i=0xDEADBEEF 2 cycles after gnt_i -> rvalid_o pulse with rdata_o=0xDEADBEEF one cycle later; be_o=0xFF on the request.
- Write during read: write granted while in S_RD_WAIT -> drained only after rvalid_o.
- Reset mid-drain: 4 queued, rst_ni low during S_WR -> all outputs 0, empty_o=1; no memory writes after release.
